// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one RAM (MAR/MBR/WMFC/rnw/MFC interface) between two requesters:
// port 0 (control unit fetch/execute) and port 1 (DMA / program loader).
// Only one RAM access is in flight at a time. The enable is held until MFC.
// After that, read data and a one-cycle ack go back to the winning port.
//
// Contention between the ports is settled round-robin. Port 0 wins the first
// contention after reset. All outputs are registered.
//
// Ports:
//   CLK, RST_N        clock; synchronous active-low reset
//   reqN/rnwN/addrN/wdataN
//                     request of port N; held stable until ackN
//   ackN              one-cycle completion pulse for port N
//   rdata             read data, valid with ack, held until the next read
//   err               valid with ack: the transfer timed out
//   gnt               one-hot current owner (bit0 = port 0), 00 when idle
//   mem_addr/mem_wdata/mem_en/mem_rnw
//                     outputs to the RAM (MAR, data, WMFC, rnw)
//   mem_rdata/mem_mfc inputs from the RAM (MBR, function complete)
//
// Optional build macro:
//   ARB_TIMEOUT_EN    When defined, an access that sees no MFC for TO_CYCLES
//                     cycles is abandoned and acked with err = 1. When it is
//                     undefined, ACCESS waits for MFC indefinitely and err is
//                     tied to 0.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int TO_CYCLES = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req0,
    input  logic          rnw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          rnw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [1:0]    gnt,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_en,
    output logic          mem_rnw,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_mfc
);

    // The timeout counter must be able to reach at least one wait cycle.
    if (TO_CYCLES < 2) begin : g_bad_to_cycles
        $error("mem_arbiter: TO_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_reg,     state_next;
    logic [1:0]    gnt_reg,       gnt_next;
    logic [1:0]    ack_reg,       ack_next;
    logic [DW-1:0] rdata_reg,     rdata_next;
    logic [AW-1:0] mem_addr_reg,  mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic          mem_en_reg,    mem_en_next;
    logic          mem_rnw_reg,   mem_rnw_next;
    // Index of the port granted most recently; a tie goes to the other port.
    logic          last_reg,      last_next;
    logic          pick;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES);
    logic [CW-1:0] to_cnt_reg, to_cnt_next;
    logic          err_reg,    err_next;
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        ack_next       = 2'b00;
        rdata_next     = rdata_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_en_next    = mem_en_reg;
        mem_rnw_next   = mem_rnw_reg;
        last_next      = last_reg;
        // 1 selects port 1. With a single request the requester wins.
        // With both requests, the port not granted last time wins.
        pick           = (req0 && req1) ? ~last_reg : req1;
`ifdef ARB_TIMEOUT_EN
        to_cnt_next    = to_cnt_reg;
        err_next       = 1'b0;
`endif

        unique case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    mem_addr_next  = pick ? addr1  : addr0;
                    mem_wdata_next = pick ? wdata1 : wdata0;
                    mem_rnw_next   = pick ? rnw1   : rnw0;
                    gnt_next       = pick ? 2'b10  : 2'b01;
                    mem_en_next    = 1'b1;
                    last_next      = pick;
                    state_next     = ACCESS;
`ifdef ARB_TIMEOUT_EN
                    to_cnt_next    = '0;
`endif
                end
            end

            ACCESS: begin
                if (mem_mfc) begin
                    // MFC takes priority over a timeout on the same edge.
                    mem_en_next = 1'b0;
                    if (mem_rnw_reg) begin
                        rdata_next = mem_rdata;
                    end
                    ack_next   = gnt_reg;
                    state_next = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt_reg == CW'(TO_CYCLES - 1)) begin
                    // TO_CYCLES enable cycles have passed without MFC.
                    mem_en_next = 1'b0;
                    ack_next    = gnt_reg;
                    err_next    = 1'b1;
                    state_next  = RESP;
                end else begin
                    to_cnt_next = to_cnt_reg + CW'(1);
                end
`endif
            end

            RESP: begin
                gnt_next   = 2'b00;
                state_next = IDLE;
            end

            default: begin
                gnt_next    = 2'b00;
                mem_en_next = 1'b0;
                state_next  = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg     <= IDLE;
            gnt_reg       <= 2'b00;
            ack_reg       <= 2'b00;
            rdata_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_en_reg    <= 1'b0;
            mem_rnw_reg   <= 1'b1;
            last_reg      <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            to_cnt_reg    <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            ack_reg       <= ack_next;
            rdata_reg     <= rdata_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_en_reg    <= mem_en_next;
            mem_rnw_reg   <= mem_rnw_next;
            last_reg      <= last_next;
`ifdef ARB_TIMEOUT_EN
            to_cnt_reg    <= to_cnt_next;
            err_reg       <= err_next;
`endif
        end
    end

    assign ack0      = ack_reg[0];
    assign ack1      = ack_reg[1];
    assign rdata     = rdata_reg;
    assign gnt       = gnt_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_en    = mem_en_reg;
    assign mem_rnw   = mem_rnw_reg;
`ifdef ARB_TIMEOUT_EN
    assign err       = err_reg;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A word-array RAM model answers each
// access after a chosen number of wait cycles. The expected grant owner
// follows the round-robin rule: a lone requester wins, and on a tie the port
// not granted last wins. Expected read data comes from the RAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req0, rnw0, req1, rnw1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err;
    logic [DW-1:0] rdata;
    logic [1:0]    gnt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_en, mem_rnw;
    logic [DW-1:0] mem_rdata;
    logic          mem_mfc;

    int            n_asserts = 0;
    int            n_fail    = 0;
    logic [DW-1:0] mem_model [256];
    logic [DW-1:0] exp_rdata;
    int            last_owner;

    always #5 CLK = ~CLK;

    mem_arbiter #(.DW(DW), .AW(AW), .TO_CYCLES(TO)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0(req0), .rnw0(rnw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .rnw1(rnw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .err(err), .gnt(gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en),
        .mem_rnw(mem_rnw), .mem_rdata(mem_rdata), .mem_mfc(mem_mfc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_owner(input logic r0, input logic r1);
        if (r0 && r1) return 1 - last_owner;
        return r1 ? 1 : 0;
    endfunction

    task automatic set_req(input int p, input logic rnw, input logic [7:0] a, input logic [7:0] w);
        if (p == 0) begin req0 = 1'b1; rnw0 = rnw; addr0 = a; wdata0 = w; end
        else        begin req1 = 1'b1; rnw1 = rnw; addr1 = a; wdata1 = w; end
        $display("req  port%0d %s addr=0x%02h wdata=0x%02h", p, rnw ? "RD" : "WR", a, w);
    endtask

    task automatic do_reset(input int cycles);
        RST_N = 1'b0;
        repeat (cycles) @(negedge CLK);
        RST_N = 1'b1;
        last_owner = 1;
        exp_rdata  = '0;
    endtask

    // Called from a falling edge where the arbiter is IDLE with requests set.
    // Returns at the falling edge of the ack cycle, with the winner's request dropped.
    task automatic serve(input int delay);
        int            owner;
        int            cyc;
        logic [7:0]    ea, ew;
        logic          erw;
        owner = pick_owner(req0, req1);
        ea    = owner ? addr1  : addr0;
        ew    = owner ? wdata1 : wdata0;
        erw   = owner ? rnw1   : rnw0;
        cyc   = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (mem_en !== 1'b1 && cyc < 20);
        chk("grant_latency", cyc, 1);
        chk("gnt", {30'd0, gnt}, owner ? 2 : 1);
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, ea});
        chk("mem_rnw", {31'd0, mem_rnw}, {31'd0, erw});
        if (!erw) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, ew});
        chk("ack_in_access", {30'd0, ack1, ack0}, 0);
        for (int i = 0; i < delay; i++) begin
            @(negedge CLK);
            chk("mem_en_hold", {31'd0, mem_en}, 1);
            chk("mem_addr_hold", {24'd0, mem_addr}, {24'd0, ea});
        end
        mem_mfc   = 1'b1;
        mem_rdata = erw ? mem_model[ea] : 8'($urandom);
        @(negedge CLK);
        mem_mfc   = 1'b0;
        mem_rdata = 8'($urandom);
        if (erw) exp_rdata = mem_model[ea];
        else     mem_model[ea] = ew;
        chk("mem_en_drop", {31'd0, mem_en}, 0);
        chk("ack", {30'd0, ack1, ack0}, owner ? 2 : 1);
        chk("err", {31'd0, err}, 0);
        chk("rdata", {24'd0, rdata}, {24'd0, exp_rdata});
        $display("xfer port%0d %s addr=0x%02h wait=%0d rdata=0x%02h ack=%b%b err=%b",
                 owner, erw ? "RD" : "WR", ea, delay, rdata, ack1, ack0, err);
        last_owner = owner;
        if (owner == 1) req1 = 1'b0;
        else            req0 = 1'b0;
    endtask

    task automatic post_resp();
        @(negedge CLK);
        chk("post_ack", {30'd0, ack1, ack0}, 0);
        chk("post_gnt", {30'd0, gnt}, 0);
        chk("post_mem_en", {31'd0, mem_en}, 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
        req0 = 0; rnw0 = 1; addr0 = 0; wdata0 = 0;
        req1 = 0; rnw1 = 1; addr1 = 0; wdata1 = 0;
        mem_rdata = 0; mem_mfc = 0;

        // Reset state.
        do_reset(3);
        chk("rst_gnt", {30'd0, gnt}, 0);
        chk("rst_mem_en", {31'd0, mem_en}, 0);
        chk("rst_mem_rnw", {31'd0, mem_rnw}, 1);
        chk("rst_mem_addr", {24'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_ack", {30'd0, ack1, ack0}, 0);
        chk("rst_rdata", {24'd0, rdata}, 0);
        chk("rst_err", {31'd0, err}, 0);

        // Single read, zero wait.
        mem_model[8'h12] = 8'hA5;
        set_req(0, 1'b1, 8'h12, 8'h00);
        serve(0);
        chk("single_rdata", {24'd0, rdata}, 32'hA5);
        post_resp();

        // Write with four wait cycles.
        set_req(1, 1'b0, 8'h40, 8'h3C);
        serve(4);
        chk("write_rdata_kept", {24'd0, rdata}, 32'hA5);
        post_resp();

        // Continuous contention after reset: 0,1,0,1.
        do_reset(2);
        set_req(0, 1'b1, 8'h40, 8'h00);
        set_req(1, 1'b0, 8'h05, 8'h77);
        for (int k = 0; k < 4; k++) begin
            serve(k % 3);
            chk("rr_winner", last_owner, k % 2);
            set_req(last_owner, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            post_resp();
        end
        req0 = 0; req1 = 0;
        @(negedge CLK);
        post_resp();

        // Stray MFC while idle.
        mem_mfc = 1'b1;
        @(negedge CLK);
        mem_mfc = 1'b0;
        chk("stray_ack", {30'd0, ack1, ack0}, 0);
        chk("stray_en", {31'd0, mem_en}, 0);
        post_resp();
        set_req(0, 1'b1, 8'h40, 8'h00);
        serve(1);
        post_resp();

        // Reset in the middle of an access.
        set_req(1, 1'b1, 8'h21, 8'h00);
        cyc = 0;
        do begin @(negedge CLK); cyc++; end while (mem_en !== 1'b1 && cyc < 20);
        chk("midrst_en_before", {31'd0, mem_en}, 1);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("midrst_en", {31'd0, mem_en}, 0);
        chk("midrst_gnt", {30'd0, gnt}, 0);
        chk("midrst_ack", {30'd0, ack1, ack0}, 0);
        @(negedge CLK);
        RST_N = 1'b1; req1 = 1'b0;
        last_owner = 1; exp_rdata = '0;
        mem_mfc = 1'b1;
        @(negedge CLK);
        mem_mfc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("midrst_no_ack", {30'd0, ack1, ack0}, 0);
            chk("midrst_rdata", {24'd0, rdata}, 0);
        end

        // Access with no MFC.
        set_req(0, 1'b1, 8'h33, 8'h00);
        cyc = 0;
        do begin @(negedge CLK); cyc++; end while (mem_en !== 1'b1 && cyc < 20);
        chk("to_en_start", {31'd0, mem_en}, 1);
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            @(negedge CLK);
            chk("to_en_hold", {31'd0, mem_en}, 1);
        end
        @(negedge CLK);
        chk("to_ack", {30'd0, ack1, ack0}, 1);
        chk("to_err", {31'd0, err}, 1);
        chk("to_en_drop", {31'd0, mem_en}, 0);
        chk("to_rdata", {24'd0, rdata}, {24'd0, exp_rdata});
        $display("xfer port0 RD addr=0x33 timeout err=%b", err);
        req0 = 1'b0;
        last_owner = 0;
        post_resp();
`else
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            chk("nto_en_hold", {31'd0, mem_en}, 1);
            chk("nto_no_ack", {30'd0, ack1, ack0}, 0);
        end
        mem_mfc = 1'b1; mem_rdata = mem_model[8'h33];
        @(negedge CLK);
        mem_mfc = 1'b0;
        exp_rdata = mem_model[8'h33];
        chk("nto_ack", {30'd0, ack1, ack0}, 1);
        chk("nto_rdata", {24'd0, rdata}, {24'd0, exp_rdata});
        $display("xfer port0 RD addr=0x33 late mfc rdata=0x%02h", rdata);
        req0 = 1'b0;
        last_owner = 0;
        post_resp();
`endif

        // Randomized traffic; a pending loser keeps its request held.
        for (int it = 0; it < 40; it++) begin
            if (!req0 && $urandom_range(0, 1) == 1)
                set_req(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            if (!req1 && $urandom_range(0, 1) == 1)
                set_req(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            if (!req0 && !req1)
                set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 15)), 8'($urandom));
            serve(int'($urandom_range(0, 3)));
            post_resp();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single RAM (MAR/MBR/WMFC/rnw/MFC interface) between the control unit's fetch/execute path (port 0) and a DMA/program-loader requester (port 1). It serialises requests and sequences one RAM access at a time, holding the enable until MFC. It returns read data and a one-cycle ack to the winning port. It sits between the requesters and the ram block, replacing the direct CU-to-RAM enable wiring.

Parameters:
DW, 8, data width (matches the 8-bit bus)
AW, 8, address width (matches MAR)
TO_CYCLES, 16, access timeout in cycles; only used when ARB_TIMEOUT_EN is defined; must be >= 2

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST_N  input  1  synchronous reset, active-low
req0  input  1  port 0 request; held high with rnw0/addr0/wdata0 stable until ack0
rnw0  input  1  port 0: 1 = read, 0 = write
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
ack0  output  1  one-cycle pulse: port 0 transfer complete
req1, rnw1, addr1, wdata1, ack1  as port 0, for port 1
rdata  output  DW  registered read data, valid in ack cycle, held until next capture
err  output  1  valid with ack: transfer timed out
gnt  output  2  one-hot current owner (bit0 = port 0); 00 when idle
mem_addr  output  AW  to MAR
mem_wdata  output  DW  write data to RAM
mem_en  output  1  to RAM enable (WMFC)
mem_rnw  output  1  to RAM rnw
mem_rdata  input  DW  from MBR
mem_mfc  input  1  memory function complete

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- Reset (RST_N low at a clock edge, from any state): state = IDLE, gnt = 00, mem_en = 0, mem_rnw = 1, mem_addr = 0, mem_wdata = 0, ack0 = ack1 = 0, rdata = 0, err = 0, last-grant pointer = 1 (port 0 wins the first contention), timeout counter = 0.
- Reset mid-access aborts the transfer. No ack is issued for it. The requester must re-request.
- IDLE: sample req0/req1.
  - Neither high: stay in IDLE.
  - One high: grant that port.
  - Both high: grant the port not equal to the last-grant pointer (round-robin).
  - On grant: latch addr/wdata/rnw into mem_addr/mem_wdata/mem_rnw, set gnt, set mem_en = 1, update the pointer, go to ACCESS.
- ACCESS: mem_en, mem_addr, mem_wdata and mem_rnw are held constant.
  - mem_mfc high at an edge: mem_en = 0. If read, capture rdata from mem_rdata. Pulse ack of the owner. Go to RESP.
- RESP: lasts one cycle; ack is high and err is valid. Next edge: ack = 0, gnt = 00, go to IDLE.
- mem_mfc is ignored outside ACCESS.
- On writes, rdata is not updated.
- Requester contract: deassert req (or present a new request) on the edge where ack is high. IDLE samples req in the cycle after RESP.
- Minimum latency: req high in IDLE at edge N → mem_en high after N → mfc high at N+1 → ack high after N+1, i.e. 2 cycles request-to-ack. Each extra mfc wait cycle adds 1.
- Throughput: at most one transfer per 3 cycles.
- Under continuous dual requests, grants alternate 0,1,0,1…

Optional Feature:
ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without mfc. When it reaches TO_CYCLES:
  - mem_en drops, and ack goes to the owner with err = 1.
  - rdata is unchanged.
  - Go to RESP.
  - mfc and timeout at the same edge: mfc wins, err = 0.
- Undefined: no counter; ACCESS waits for mfc indefinitely; err is tied to 0.

Test Plan:
- Reset: hold RST_N low 2 cycles mid-ACCESS (mem_en = 1) → next cycle mem_en = 0, gnt = 00, ack0 = ack1 = 0, no ack for the aborted transfer.
- Single read: req0 = 1, rnw0 = 1, addr0 = 0x12; mem_mfc one cycle after mem_en with mem_rdata = 0xA5 → mem_addr = 0x12, ack0 pulse 2 cycles after request, rdata = 0xA5, err = 0.
- Write with wait: req1 = 1, rnw1 = 0, addr1 = 0x40, wdata1 = 0x3C; mfc delayed 4 cycles → mem_en high exactly 5 cycles, mem_wdata = 0x3C, mem_rnw = 0, ack1 once, rdata unchanged.
- Contention: req0 = req1 = 1 continuously for 4 transfers after reset → grant order 0,1,0,1; acks never overlap; gnt is one-hot during ACCESS.
- Stray mfc: pulse mem_mfc while IDLE → no ack, no state change; a following read completes normally.
- Timeout (ARB_TIMEOUT_EN, TO_CYCLES = 4): read with mfc never asserted → mem_en high 4 cycles, then ack0 with err = 1, then IDLE; without the macro, mem_en stays high indefinitely.
